// File: rtl/riscv_pkg.sv
// Shared RV32 control-transfer encodings and the branch/jump FSM state type.
package riscv_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNCT3_W = 3;

  localparam logic [OPCODE_W-1:0] B_TYPE   = 7'b1100011;
  localparam logic [OPCODE_W-1:0] JAL_INS  = 7'b1101111;
  localparam logic [OPCODE_W-1:0] JALR_INS = 7'b1100111;

  localparam logic [FUNCT3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [FUNCT3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [FUNCT3_W-1:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } br_state_e;

  // True for any opcode this block acts on.
  function automatic logic is_ctrl_op(input logic [OPCODE_W-1:0] op);
    return (op == B_TYPE) || (op == JAL_INS) || (op == JALR_INS);
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch-condition evaluation from funct3 and the forwarded operands.
module br_cond_eval
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic [XLEN-1:0]     rs1,
  input  logic [XLEN-1:0]     rs2,
  output logic                taken_c
);

  logic eq_c;
  logic lt_c;
  logic ltu_c;

  assign eq_c  = (rs1 == rs2);
  assign lt_c  = ($signed(rs1) < $signed(rs2));
  assign ltu_c = (rs1 < rs2);

  // Reserved encodings 010/011 never branch.
  always_comb begin
    taken_c = 1'b0;
    case (funct3)
      F3_BEQ:  taken_c = eq_c;
      F3_BNE:  taken_c = !eq_c;
      F3_BLT:  taken_c = lt_c;
      F3_BGE:  taken_c = !lt_c;
      F3_BLTU: taken_c = ltu_c;
      F3_BGEU: taken_c = !ltu_c;
      default: taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/br_jmp_ctrl.sv
// EX-stage branch/jump resolution: target generation, PC redirect handshake to
// fetch, wrong-path flush sequencing and taken-redirect statistics.
module br_jmp_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic [OPCODE_W-1:0] ex_opcode,
  input  logic [FUNCT3_W-1:0] ex_funct3,
  input  logic [XLEN-1:0]     ex_pc,
  input  logic [XLEN-1:0]     ex_imm,
  input  logic [XLEN-1:0]     ex_rs1,
  input  logic [XLEN-1:0]     ex_rs2,
  input  logic                redirect_ready,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc,
  output logic [XLEN-1:0]     link_addr,
  output logic                stall_ex,
  output logic                flush_if,
  output logic                flush_id,
  output logic                misalign_exc,
  output logic [CNT_W-1:0]    taken_count
);

  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  br_state_e       state;
  logic [FC_W-1:0] flush_cnt;

  logic            is_br_c;
  logic            is_jal_c;
  logic            is_jalr_c;
  logic            is_link_c;
  logic            cond_c;
  logic            taken_c;
  logic            decide_c;
  logic [XLEN-1:0] base_c;
  logic [XLEN-1:0] target_c;

  assign is_br_c   = (ex_opcode == B_TYPE);
  assign is_jal_c  = (ex_opcode == JAL_INS);
  assign is_jalr_c = (ex_opcode == JALR_INS);
  assign is_link_c = is_jal_c || is_jalr_c;

  br_cond_eval #(
    .XLEN (XLEN)
  ) u_cond (
    .funct3  (ex_funct3),
    .rs1     (ex_rs1),
    .rs2     (ex_rs2),
    .taken_c (cond_c)
  );

  assign taken_c  = is_link_c || (is_br_c && cond_c);
  assign decide_c = (state == IDLE) && ex_valid && is_ctrl_op(ex_opcode);

  // Target adder; JALR clears bit 0 of the computed address.
  always_comb begin
    base_c   = is_jalr_c ? ex_rs1 : ex_pc;
    target_c = base_c + ex_imm;
    if (is_jalr_c) begin
      target_c[0] = 1'b0;
    end
  end

  // Redirect/flush FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      flush_cnt      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      link_addr      <= '0;
      stall_ex       <= 1'b0;
      flush_if       <= 1'b0;
      flush_id       <= 1'b0;
      misalign_exc   <= 1'b0;
      taken_count    <= '0;
    end else begin
      misalign_exc <= 1'b0;
      case (state)
        IDLE: begin
          if (decide_c) begin
            if (is_link_c) begin
              link_addr <= ex_pc + XLEN'(4);
            end
            if (taken_c) begin
              if (target_c[1]) begin
                misalign_exc <= 1'b1;
              end else begin
                state          <= REDIRECT;
                redirect_pc    <= target_c;
                redirect_valid <= 1'b1;
                stall_ex       <= 1'b1;
              end
            end
          end
        end
        REDIRECT: begin
          // Hold request and target until fetch takes it.
          if (redirect_ready) begin
            state          <= FLUSH;
            redirect_valid <= 1'b0;
            stall_ex       <= 1'b0;
            flush_if       <= 1'b1;
            flush_id       <= 1'b1;
            flush_cnt      <= FC_W'(FLUSH_CYCLES - 1);
            if (taken_count != '1) begin
              taken_count <= taken_count + CNT_W'(1);
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state    <= IDLE;
            flush_if <= 1'b0;
            flush_id <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - FC_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_br_jmp_ctrl.sv
// Directed bench for br_jmp_ctrl with a cycle-level reference model and literal spot checks.
module tb_br_jmp_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned FC    = 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid;
  logic [6:0]       ex_opcode;
  logic [2:0]       ex_funct3;
  logic [XLEN-1:0]  ex_pc, ex_imm, ex_rs1, ex_rs2;
  logic             redirect_ready;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic [XLEN-1:0]  link_addr;
  logic             stall_ex, flush_if, flush_id, misalign_exc;
  logic [CNT_W-1:0] taken_count;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  br_jmp_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_opcode      (ex_opcode),
    .ex_funct3      (ex_funct3),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .redirect_ready (redirect_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .link_addr      (link_addr),
    .stall_ex       (stall_ex),
    .flush_if       (flush_if),
    .flush_id       (flush_id),
    .misalign_exc   (misalign_exc),
    .taken_count    (taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pending-redirect flag plus a count of flush cycles still owed.
  bit              m_pending;
  int              m_flush_left;
  logic [XLEN-1:0] m_pc, m_link;
  bit              m_mis;
  int              m_cnt;

  function automatic bit branch_ok(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) <  $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a <  b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [XLEN-1:0] tgt;
    bit tk;
    if (rst) begin
      m_pending = 0; m_flush_left = 0; m_pc = '0; m_link = '0; m_mis = 0; m_cnt = 0;
    end else begin
      m_mis = 0;
      if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (m_pending) begin
        if (redirect_ready) begin
          m_pending    = 0;
          m_flush_left = FC;
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
      end else if (ex_valid && (ex_opcode == OP_B || ex_opcode == OP_JAL || ex_opcode == OP_JALR)) begin
        tk  = (ex_opcode != OP_B) || branch_ok(ex_funct3, ex_rs1, ex_rs2);
        tgt = (ex_opcode == OP_JALR) ? ((ex_rs1 + ex_imm) & ~32'd1) : (ex_pc + ex_imm);
        if (ex_opcode != OP_B) m_link = ex_pc + 32'd4;
        if (tk) begin
          if (tgt[1]) m_mis = 1;
          else begin
            m_pending = 1;
            m_pc      = tgt;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("m_redirect_valid", 64'(redirect_valid), 64'(m_pending));
      chk("m_stall_ex", 64'(stall_ex), 64'(m_pending));
      chk("m_flush_if", 64'(flush_if), 64'(m_flush_left > 0));
      chk("m_flush_id", 64'(flush_id), 64'(m_flush_left > 0));
      chk("m_misalign", 64'(misalign_exc), 64'(m_mis));
      chk("m_link_addr", 64'(link_addr), 64'(m_link));
      chk("m_taken_count", 64'(taken_count), 64'(m_cnt));
      if (m_pending) chk("m_redirect_pc", 64'(redirect_pc), 64'(m_pc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] r1, input logic [31:0] r2);
    ex_valid = 1'b1; ex_opcode = op; ex_funct3 = f3;
    ex_pc = pc; ex_imm = imm; ex_rs1 = r1; ex_rs2 = r2;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0; ex_opcode = OP_ALU; ex_funct3 = 3'b000;
    ex_pc = '0; ex_imm = '0; ex_rs1 = '0; ex_rs2 = '0;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] r1;
    logic [31:0] r2;
    bit          exp;
  } cond_vec_t;

  cond_vec_t cv[8];

  initial begin
    idle_ex();
    redirect_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    armed = 1'b1;
    chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    chk("rst_taken_count", 64'(taken_count), 64'd0);
    chk("rst_flush_if", 64'(flush_if), 64'd0);

    // BEQ taken, zero-wait accept, two flush cycles.
    set_ex(OP_B, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5);
    tick();
    idle_ex();
    chk("beq_valid", 64'(redirect_valid), 64'd1);
    chk("beq_pc", 64'(redirect_pc), 64'h120);
    chk("beq_stall", 64'(stall_ex), 64'd1);
    tick();
    chk("beq_flush1", 64'(flush_if), 64'd1);
    chk("beq_count", 64'(taken_count), 64'd1);
    tick();
    chk("beq_flush2", 64'(flush_id), 64'd1);
    tick();
    chk("beq_flush_end", 64'(flush_if), 64'd0);

    // Signed vs unsigned less-than on the same operands.
    set_ex(OP_B, 3'b100, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1);
    tick();
    idle_ex();
    chk("blt_valid", 64'(redirect_valid), 64'd1);
    chk("blt_pc", 64'(redirect_pc), 64'h340);
    tick(); tick(); tick();
    set_ex(OP_B, 3'b110, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1);
    tick();
    idle_ex();
    chk("bltu_valid", 64'(redirect_valid), 64'd0);
    chk("bltu_count", 64'(taken_count), 64'd2);

    // JALR landing on bit1=1 traps; bit0 is cleared before the alignment test.
    set_ex(OP_JALR, 3'b000, 32'h40, 32'h0, 32'h1003, 32'd0);
    tick();
    idle_ex();
    chk("jalr3_mis", 64'(misalign_exc), 64'd1);
    chk("jalr3_link", 64'(link_addr), 64'h44);
    chk("jalr3_valid", 64'(redirect_valid), 64'd0);
    set_ex(OP_JALR, 3'b000, 32'h40, 32'h0, 32'h1001, 32'd0);
    tick();
    idle_ex();
    chk("jalr1_mis", 64'(misalign_exc), 64'd0);
    chk("jalr1_pc", 64'(redirect_pc), 64'h1000);
    chk("jalr1_link", 64'(link_addr), 64'h44);
    tick(); tick(); tick();

    // JAL to a misaligned target.
    set_ex(OP_JAL, 3'b000, 32'h200, 32'h2, 32'd0, 32'd0);
    tick();
    idle_ex();
    chk("jal_mis", 64'(misalign_exc), 64'd1);
    chk("jal_link", 64'(link_addr), 64'h204);
    chk("jal_valid", 64'(redirect_valid), 64'd0);
    tick();
    chk("jal_mis_pulse", 64'(misalign_exc), 64'd0);

    // BNE with back-pressure; a JAL presented while waiting must be ignored.
    redirect_ready = 1'b0;
    set_ex(OP_B, 3'b001, 32'h500, 32'h100, 32'd1, 32'd2);
    tick();
    set_ex(OP_JAL, 3'b000, 32'h800, 32'h10, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bne_hold_valid", 64'(redirect_valid), 64'd1);
      chk("bne_hold_stall", 64'(stall_ex), 64'd1);
      chk("bne_hold_pc", 64'(redirect_pc), 64'h600);
      tick();
    end
    chk("bne_hold_link", 64'(link_addr), 64'h204);
    redirect_ready = 1'b1;
    idle_ex();
    tick();
    chk("bne_accept_flush", 64'(flush_if), 64'd1);
    chk("bne_count", 64'(taken_count), 64'd4);
    tick(); tick();

    // Remaining condition encodings, including the reserved ones.
    cv[0] = '{3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0};
    cv[1] = '{3'b101, 32'd7, 32'd7, 1'b1};
    cv[2] = '{3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1};
    cv[3] = '{3'b111, 32'd1, 32'd2, 1'b0};
    cv[4] = '{3'b010, 32'd3, 32'd3, 1'b0};
    cv[5] = '{3'b011, 32'd0, 32'd9, 1'b0};
    cv[6] = '{3'b000, 32'd4, 32'd5, 1'b0};
    cv[7] = '{3'b001, 32'd4, 32'd4, 1'b0};
    for (int i = 0; i < 8; i++) begin
      set_ex(OP_B, cv[i].f3, 32'h1000, 32'h80, cv[i].r1, cv[i].r2);
      tick();
      idle_ex();
      chk("cond_vec", 64'(redirect_valid), 64'(cv[i].exp));
      if (cv[i].exp) begin
        tick(); tick(); tick();
      end
    end

    // Non-control opcode is ignored.
    set_ex(OP_ALU, 3'b000, 32'h40, 32'h8, 32'd1, 32'd1);
    tick();
    idle_ex();
    chk("alu_ignored", 64'(redirect_valid), 64'd0);

    // Reset during the first flush cycle, then a normal decision.
    set_ex(OP_B, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5);
    tick();
    idle_ex();
    tick();
    chk("pre_rst_flush", 64'(flush_if), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_flush", 64'(flush_if), 64'd0);
    chk("rst_mid_count", 64'(taken_count), 64'd0);
    chk("rst_mid_link", 64'(link_addr), 64'd0);
    set_ex(OP_B, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5);
    tick();
    idle_ex();
    chk("post_rst_valid", 64'(redirect_valid), 64'd1);
    chk("post_rst_pc", 64'(redirect_pc), 64'h120);
    tick(); tick(); tick();
    chk("post_rst_count", 64'(taken_count), 64'd1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
